regfile_sequencer: RTL and testbench

- Multi-cycle control FSM that sequences the accumulator/register-file datapath: a `res` accumulator plus reg0..reg7.
- Accepts 9-bit instructions from the fetch stage over a valid/ready handshake.
- Drives the register-file strobes (cpyin, cpyout, memLoad, comp, reg_sel) and runs data-memory load/store transactions with a timeout.
- Signals halt and error status to the top level.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/mem_wait_timer.sv | 30 +++
 rtl/regfile_sequencer.sv | 153 +++++++++++++++
 tb/tb_regfile_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Opcode and state encodings shared by the register-file sequencer.
// Instruction fields: op=[8:6], sub=[5:3], rs=[2:0].
package seq_pkg;

    localparam logic [2:0] OP_ALU    = 3'b000;
    localparam logic [2:0] OP_CPYIN  = 3'b001;
    localparam logic [2:0] OP_CPYOUT = 3'b010;
    localparam logic [2:0] OP_LOAD   = 3'b011;
    localparam logic [2:0] OP_STORE  = 3'b100;
    localparam logic [2:0] OP_COMP   = 3'b101;
    localparam logic [2:0] OP_RSVD   = 3'b110;
    localparam logic [2:0] OP_HALT   = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_MEM  = 3'd2,
        S_WB   = 3'd3,
        S_HALT = 3'd4
    } state_e;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ack; flags the final allowed cycle.
// last_o is high in the cycle whose increment would reach TIMEOUT.
module mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign last_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/regfile_sequencer.sv
// Multi-cycle control FSM for the accumulator/register-file datapath.
// All outputs are registered and change only on posedge (or async reset).
module regfile_sequencer
    import seq_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] instr,
    input  logic       instr_valid,
    output logic       instr_ready,
    output logic [2:0] reg_sel,
    output logic       cpyin,
    output logic       cpyout,
    output logic       memLoad,
    output logic       comp,
    output logic [2:0] alu_op,
    output logic       mem_req,
    output logic       mem_we,
    input  logic       mem_ack,
    output logic       halted,
    output logic       err
);

    state_e     state_q;
    logic [2:0] op_q;
    logic       ready_q;
    logic [2:0] reg_sel_q;
    logic [2:0] alu_op_q;
    logic       cpyin_q;
    logic       cpyout_q;
    logic       memload_q;
    logic       comp_q;
    logic       mem_req_q;
    logic       mem_we_q;
    logic       halted_q;
    logic       err_q;

    logic       in_mem;
    logic       tmr_last;
    logic       tmr_clr;
    logic [2:0] in_op;

    assign in_op   = instr[8:6];
    assign in_mem  = (state_q == S_MEM);
    assign tmr_clr = !in_mem || mem_ack || tmr_last;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tmr_clr),
        .en_i   (in_mem),
        .last_o (tmr_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ALU;
            ready_q   <= 1'b0;
            reg_sel_q <= '0;
            alu_op_q  <= '0;
            cpyin_q   <= 1'b0;
            cpyout_q  <= 1'b0;
            memload_q <= 1'b0;
            comp_q    <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            cpyin_q   <= 1'b0;
            cpyout_q  <= 1'b0;
            memload_q <= 1'b0;
            comp_q    <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    ready_q   <= !halted_q;
                    reg_sel_q <= '0;
                    if (instr_valid && ready_q) begin
                        state_q   <= S_EXEC;
                        ready_q   <= 1'b0;
                        op_q      <= in_op;
                        alu_op_q  <= instr[5:3];
                        reg_sel_q <= instr[2:0];
                        cpyin_q   <= (in_op == OP_CPYIN);
                        cpyout_q  <= (in_op == OP_CPYOUT);
                        comp_q    <= (in_op == OP_COMP);
                    end
                end
                S_EXEC: begin
                    if (is_mem_op(op_q)) begin
                        state_q   <= S_MEM;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= (op_q == OP_STORE);
                    end else if (op_q == OP_HALT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        reg_sel_q <= '0;
                    end
                end
                S_MEM: begin
                    if (mem_ack && !mem_we_q) begin
                        state_q   <= S_WB;
                        memload_q <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else if (mem_ack || tmr_last) begin
                        state_q   <= S_IDLE;
                        ready_q   <= 1'b1;
                        reg_sel_q <= '0;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_q     <= err_q || !mem_ack;
                    end
                end
                S_WB: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    reg_sel_q <= '0;
                end
                S_HALT: begin
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign reg_sel     = reg_sel_q;
    assign alu_op      = alu_op_q;
    assign cpyin       = cpyin_q;
    assign cpyout      = cpyout_q;
    assign memLoad     = memload_q;
    assign comp        = comp_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign halted      = halted_q;
    assign err         = err_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer: driver queues expected events,
// an independent negedge monitor pops and compares what the DUT produces.
module tb_regfile_sequencer;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 255;

    localparam int EV_CPYIN   = 1;
    localparam int EV_CPYOUT  = 2;
    localparam int EV_MEMLOAD = 3;
    localparam int EV_COMP    = 4;
    localparam int EV_ERR     = 5;
    localparam int EV_HALT    = 6;

    typedef struct {
        int         kind;
        logic [2:0] rs;
        logic [2:0] sub;
    } ev_t;

    typedef struct {
        logic we;
        int   len;
    } mem_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] reg_sel;
    logic       cpyin;
    logic       cpyout;
    logic       memLoad;
    logic       comp;
    logic [2:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack = 1'b0;
    logic       halted;
    logic       err;

    int checks = 0;
    int failures = 0;

    ev_t  evq[$];
    mem_t memq[$];
    int   dlyq[$];
    logic err_model = 1'b0;

    regfile_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .reg_sel     (reg_sel),
        .cpyin       (cpyin),
        .cpyout      (cpyout),
        .memLoad     (memLoad),
        .comp        (comp),
        .alu_op      (alu_op),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .halted      (halted),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] all_outs();
        return {instr_ready, reg_sel, cpyin, cpyout, memLoad, comp,
                alu_op, mem_req, mem_we, halted, err};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks in the dly-th request cycle, random noise otherwise.
    int rcnt = 0;
    int rdly = NEVER;
    always @(negedge clk) begin
        if (!rst_n) begin
            rcnt = 0;
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (rcnt == 0) rdly = (dlyq.size() > 0) ? dlyq.pop_front() : NEVER;
            rcnt++;
            mem_ack = (rcnt == rdly);
        end else begin
            rcnt = 0;
            mem_ack = ($urandom_range(0, 7) == 0);
        end
    end

    task automatic pop_check(input int kind, input logic [2:0] rs, input logic [2:0] sub);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event: got kind %0d rs %0d expected none at %0t",
                     kind, rs, $time);
            return;
        end
        e = evq.pop_front();
        if (e.kind != kind) begin
            failures++;
            $display("FAIL event_kind: got %0d expected %0d at %0t", kind, e.kind, $time);
        end else if (kind <= EV_COMP && (e.rs != rs || e.sub != sub)) begin
            failures++;
            $display("FAIL event_fields: got rs %0d sub %0d expected rs %0d sub %0d at %0t",
                     rs, sub, e.rs, e.sub, $time);
        end
    endtask

    // Monitor
    int   run = 0;
    logic err_p = 1'b0;
    logic halt_p = 1'b0;
    always @(negedge clk) begin
        int nstb;
        int k;
        mem_t m;
        if (!rst_n) begin
            run = 0;
            err_p = 1'b0;
            halt_p = 1'b0;
        end else begin
            nstb = int'(cpyin) + int'(cpyout) + int'(memLoad) + int'(comp);
            if (nstb > 0) begin
                check("strobe_onehot", nstb, 1);
                k = cpyin ? EV_CPYIN : cpyout ? EV_CPYOUT : memLoad ? EV_MEMLOAD : EV_COMP;
                pop_check(k, reg_sel, alu_op);
            end
            if (err && !err_p) pop_check(EV_ERR, reg_sel, alu_op);
            if (halted && !halt_p) pop_check(EV_HALT, reg_sel, alu_op);
            check("err_sticky", int'(err || !err_p), 1);
            if (halted) check("ready_low_halted", int'(instr_ready), 0);
            if (mem_req) begin
                run++;
                if (memq.size() == 0) check("mem_req_unexpected", 1, 0);
                else check("mem_we", int'(mem_we), int'(memq[0].we));
            end else if (run > 0) begin
                if (memq.size() > 0) begin
                    m = memq.pop_front();
                    check("mem_req_cycles", run, m.len);
                end
                run = 0;
            end
            err_p = err;
            halt_p = halted;
        end
    end

    task automatic wait_ready(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    // Reference model: expected observable effects of one instruction.
    task automatic issue(input logic [8:0] ins, input int dly);
        logic [2:0] op;
        logic [2:0] sub;
        logic [2:0] rs;
        logic ok;
        bit   tmo;
        op = ins[8:6];
        sub = ins[5:3];
        rs = ins[2:0];
        wait_ready(ok);
        if (!ok) return;
        case (op)
            3'd1: evq.push_back('{EV_CPYIN, rs, sub});
            3'd2: evq.push_back('{EV_CPYOUT, rs, sub});
            3'd3, 3'd4: begin
                tmo = (dly > TIMEOUT);
                dlyq.push_back(dly);
                memq.push_back('{op == 3'd4, tmo ? TIMEOUT : dly});
                if (tmo) begin
                    if (!err_model) evq.push_back('{EV_ERR, rs, sub});
                    err_model = 1'b1;
                end else if (op == 3'd3) begin
                    evq.push_back('{EV_MEMLOAD, rs, sub});
                end
            end
            3'd5: evq.push_back('{EV_COMP, rs, sub});
            3'd7: evq.push_back('{EV_HALT, rs, sub});
            default: ;
        endcase
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 9'($urandom);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic ok;
        int   d;
        logic [2:0] op;

        #3;
        check("reset_outputs", int'(all_outs()), 0);
        @(negedge clk);
        check("reset_held_outputs", int'(all_outs()), 0);
        rst_n = 1'b1;

        wait_ready(ok);
        check("ready_after_reset", int'(ok), 1);
        issue(9'b001_000_011, 0);
        @(negedge clk);
        check("cpyin_r3", int'(cpyin), 1);
        check("cpyin_reg_sel", int'(reg_sel), 3);
        @(negedge clk);
        check("cpyin_one_cycle", int'(cpyin), 0);
        check("idle_ready", int'(instr_ready), 1);

        issue(9'b011_000_101, 4);
        settle();
        issue(9'b011_010_110, TIMEOUT);
        issue(9'b100_001_100, TIMEOUT);
        settle();
        check("ack_at_timeout_no_err", int'(err), 0);

        issue(9'b100_000_010, NEVER);
        repeat (TIMEOUT + 4) @(negedge clk);
        check("store_timeout_err", int'(err), 1);

        for (int n = 0; n < 150; n++) begin
            op = 3'($urandom_range(0, 6));
            d = ($urandom_range(0, 5) == 0) ? NEVER : $urandom_range(1, TIMEOUT);
            issue({op, 6'($urandom)}, d);
        end
        settle();
        check("err_still_set", int'(err), 1);

        issue(9'b100_000_001, NEVER);
        for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
        check("mem_req_before_reset", int'(mem_req), 1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'(all_outs()), 0);
        evq.delete();
        memq.delete();
        dlyq.delete();
        err_model = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ready(ok);
        check("ready_after_midreset", int'(ok), 1);
        check("err_cleared", int'(err), 0);

        issue(9'b101_011_111, 0);
        issue(9'b111_000_000, 0);
        for (int i = 0; i < 20 && !halted; i++) @(negedge clk);
        check("halted_set", int'(halted), 1);
        instr_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            instr = 9'($urandom);
            @(negedge clk);
            check("halt_absorbing", int'(halted), 1);
        end
        instr_valid = 1'b0;
        settle();
        check("events_drained", evq.size(), 0);
        check("mem_drained", memq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
